button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Upstream input stage of tamagotchi_fsm. It takes the raw, bouncy, asynchronous push-buttons (salud, energia, hambre, diversion, reset, test).
- For each button it produces clean, clk-synchronous signals: a level, a one-cycle press pulse, a one-cycle long-hold pulse (the 5 s reset/test hold) and a one-cycle short-release pulse.
- All N_BTN lanes are identical and independent; the FSM consumes the pulses directly.

Parameters:
- N_BTN, 6, number of button lanes; bit order is salud, energia, hambre, diversion, reset, test (bit 0 = salud).
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized samples required to accept a press or release; must be >= 2. Default is 20 ms at 50 MHz.
- LONG_CYCLES, 250000000, hold length after btn_press that raises btn_long; must be > DEBOUNCE_CYCLES. Default is 5 s at 50 MHz.
- CNT_W, $clog2(LONG_CYCLES+1), per-lane counter width (derived; do not override).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- btn_raw  in  N_BTN  raw buttons, active-high, asynchronous to clk.
- btn_level  out  N_BTN  debounced level.
- btn_press  out  N_BTN  one-cycle pulse on accepted press.
- btn_long  out  N_BTN  one-cycle pulse when a press has been held LONG_CYCLES.
- btn_short  out  N_BTN  one-cycle pulse on accepted release, only if btn_long did not fire during that press.

Behaviour:
- Synchronizer: two-flop per lane (sync1, sync2); s = sync2. Both flops reset to 0.
- Reset: on any clk edge with reset=1, all lanes go to IDLE, counters clear, and btn_level/press/long/short all = 0. Reset overrides any in-progress count. A button still held when reset drops is re-debounced from IDLE and produces a fresh btn_press.
- All outputs are registered. Pulses are high for exactly one cycle and default to 0 every cycle.
- Per-lane FSM states: IDLE, DEB_PRESS, HELD, LONG_DONE, DEB_REL_H, DEB_REL_L.
  - IDLE (level 0): on s=1, go to DEB_PRESS with cnt=1.
  - DEB_PRESS (level 0):
    - s=0: go to IDLE (glitch rejected, no output).
    - s=1 and cnt<DEBOUNCE_CYCLES-1: cnt++.
    - s=1 and cnt==DEBOUNCE_CYCLES-1: go to HELD with cnt=0, level<=1, press<=1.
  - HELD (level 1):
    - s=1: cnt++; when cnt==LONG_CYCLES-1, go to LONG_DONE and long<=1.
    - s=0: go to DEB_REL_H with cnt=1.
  - LONG_DONE (level 1): no further pulses while held. On s=0, go to DEB_REL_L with cnt=1.
  - DEB_REL_H / DEB_REL_L (level stays 1):
    - s=1: return to HELD (cnt=0, hold timing restarts) or to LONG_DONE, respectively.
    - s=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE with level<=0. DEB_REL_H also sets short<=1; DEB_REL_L emits no short.
    - Otherwise: cnt++.
- Timing, with edge 0 = first clk edge sampling btn_raw=1 and raw held stable:
  - sync2=1 after edge 1; FSM leaves IDLE at edge 2.
  - btn_press and btn_level rise after edge DEBOUNCE_CYCLES+1.
  - btn_long rises exactly LONG_CYCLES edges after the btn_press edge.
  - Release timing is symmetric: level falls, and short pulses, after edge DEBOUNCE_CYCLES+1, counted from the first edge sampling raw=0.
- btn_long fires at most once per press. btn_short and btn_long are mutually exclusive per press.
- Simultaneous presses on different lanes are fully independent; several bits may pulse in the same cycle.
- Counter never wraps: the maximum value reached is LONG_CYCLES-1 and fits in CNT_W.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, N_BTN=6):
- Reset: hold reset=1 for 3 cycles with btn_raw=6'h3F, then release reset. All outputs are 0 during reset. btn_press=6'h3F pulses once at edge 5 after release, and btn_level=6'h3F from then on.
- Clean short press, lane 0: raw high 10 cycles then low. btn_press[0] is 1 for one cycle at edge 5, btn_level[0]=1. btn_short[0] pulses once 5 edges after the first low sample, and level drops on the same edge. btn_long[0] never asserts.
- Bounce rejection, lane 2: raw toggles 1,1,0,1,1,0 and then goes low. No output changes on any lane. Repeat with a 2-cycle low glitch during HELD: level stays 1, no short, no second press.
- Long hold, lane 4: raw held 40 cycles. btn_press[4] fires at edge 5, btn_long[4] exactly 20 edges later, once only. On release, btn_short[4] stays 0 and level falls after debounce. A release glitch in LONG_DONE produces no second btn_long.
- Simultaneous lanes: lanes 1 and 3 rise on the same edge and lane 1 releases early. Both press pulses land in the same cycle. Lane 1 gets short, lane 3 gets long, with no cross-lane interference.
- Reset mid-hold: assert reset at hold cycle 15 on lane 5, with raw kept high. Outputs clear immediately. After reset drops, a new press fires at edge 5 and long fires 20 edges after that; there is no carry-over of the old count.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: turns raw, bouncy, asynchronous push-buttons into clean
// clk-synchronous signals for the tamagotchi FSM. Every lane is identical and
// independent. Each lane produces a debounced level, a one-cycle press pulse,
// a one-cycle long-hold pulse and a one-cycle short-release pulse.
//
// Bit order of every vector: 0 salud, 1 energia, 2 hambre, 3 diversion,
// 4 reset, 5 test.
//
// Parameter constraints: DEBOUNCE_CYCLES >= 2, LONG_CYCLES > DEBOUNCE_CYCLES.
// The per-lane counter never goes above LONG_CYCLES-1, so CNT_W bits are
// enough and the counter cannot wrap.
//
// dbg_state carries each lane's FSM state (3 bits per lane, lane i at
// [3*i +: 3]) using the lane_state_e encoding below.
module button_conditioner #(
  parameter  int N_BTN           = 6,
  parameter  int DEBOUNCE_CYCLES = 1000000,
  parameter  int LONG_CYCLES     = 250000000,
  localparam int CNT_W           = $clog2(LONG_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_BTN-1:0]   btn_raw,
  output logic [N_BTN-1:0]   btn_level,
  output logic [N_BTN-1:0]   btn_press,
  output logic [N_BTN-1:0]   btn_long,
  output logic [N_BTN-1:0]   btn_short,
  output logic [3*N_BTN-1:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEB_PRESS = 3'd1,
    HELD      = 3'd2,
    LONG_DONE = 3'd3,
    DEB_REL_H = 3'd4,
    DEB_REL_L = 3'd5
  } lane_state_e;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;

  // Two-flop synchronizer per lane; raw buttons are asynchronous to clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    lane_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             press_q;
    logic             long_q;
    logic             short_q;
    logic             s;

    assign s = sync2_q[i];

    // Lane FSM: debounce press/release, time the long hold, emit pulses.
    // Pulses default low every cycle so each lasts exactly one clock.
    // A bounce during a release returns to the held state it came from;
    // from HELD the hold timing restarts, from LONG_DONE no second long fires.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        long_q  <= 1'b0;
        short_q <= 1'b0;
      end else begin
        press_q <= 1'b0;
        long_q  <= 1'b0;
        short_q <= 1'b0;
        unique case (state_q)
          IDLE: begin
            if (s) begin
              state_q <= DEB_PRESS;
              cnt_q   <= CNT_ONE;
            end
          end
          DEB_PRESS: begin
            if (!s) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_q == DEB_LAST) begin
              state_q <= HELD;
              cnt_q   <= '0;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          HELD: begin
            if (!s) begin
              state_q <= DEB_REL_H;
              cnt_q   <= CNT_ONE;
            end else if (cnt_q == LONG_LAST) begin
              state_q <= LONG_DONE;
              cnt_q   <= '0;
              long_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          LONG_DONE: begin
            if (!s) begin
              state_q <= DEB_REL_L;
              cnt_q   <= CNT_ONE;
            end
          end
          DEB_REL_H, DEB_REL_L: begin
            if (s) begin
              state_q <= (state_q == DEB_REL_H) ? HELD : LONG_DONE;
              cnt_q   <= '0;
            end else if (cnt_q == DEB_LAST) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              level_q <= 1'b0;
              short_q <= (state_q == DEB_REL_H);
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end
        endcase
      end
    end

    assign btn_level[i]       = level_q;
    assign btn_press[i]       = press_q;
    assign btn_long[i]        = long_q;
    assign btn_short[i]       = short_q;
    assign dbg_state[3*i +: 3] = state_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// The reference model works on run lengths of the synchronized samples:
// a level change needs DEBOUNCE consecutive opposite samples, and a long
// pulse needs LONG uninterrupted high samples after the press (or after a
// bounced release returned to the held state).
module tb_button_conditioner;
  localparam int N = 6;
  localparam int D = 4;
  localparam int L = 20;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_long;
  logic [N-1:0] btn_short;
  logic [3*N-1:0] dbg_state;

  button_conditioner #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_long(btn_long),
    .btn_short(btn_short),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  wire [4*N-1:0] obs = {btn_level, btn_press, btn_long, btn_short};
  logic [4*N-1:0] exp_q[$];
  logic [4*N-1:0] exp_v;

  // Reference model state
  logic [N-1:0] m_sy1, m_sy2, m_level, m_press, m_long, m_short, m_long_done;
  int m_hi_run [N];
  int m_lo_run [N];
  int m_hold   [N];

  function automatic void model_edge(input logic rst, input logic [N-1:0] raw);
    logic [N-1:0] s;
    s = m_sy2;
    m_press = '0;
    m_long  = '0;
    m_short = '0;
    if (rst) begin
      m_sy1 = '0; m_sy2 = '0; m_level = '0; m_long_done = '0;
      for (int i = 0; i < N; i++) begin
        m_hi_run[i] = 0; m_lo_run[i] = 0; m_hold[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!m_level[i]) begin
          if (s[i]) m_hi_run[i]++; else m_hi_run[i] = 0;
          if (m_hi_run[i] == D) begin
            m_level[i] = 1'b1; m_press[i] = 1'b1; m_long_done[i] = 1'b0;
            m_hold[i] = 0; m_lo_run[i] = 0; m_hi_run[i] = 0;
          end
        end else if (s[i]) begin
          if (m_lo_run[i] > 0) begin
            m_lo_run[i] = 0;
            m_hold[i]   = 0;
          end else begin
            m_hold[i]++;
            if (m_hold[i] == L && !m_long_done[i]) begin
              m_long[i] = 1'b1; m_long_done[i] = 1'b1;
            end
          end
        end else begin
          m_lo_run[i]++;
          if (m_lo_run[i] == D) begin
            m_level[i] = 1'b0; m_short[i] = !m_long_done[i];
            m_lo_run[i] = 0; m_hi_run[i] = 0;
          end
        end
      end
      m_sy2 = m_sy1;
      m_sy1 = raw;
    end
    exp_q.push_back({m_level, m_press, m_long, m_short});
  endfunction

  // Driver: one clock edge; model sees the inputs present at that edge
  task automatic tick();
    logic [N-1:0] raw_s;
    logic         rst_s;
    raw_s = btn_raw;
    rst_s = reset;
    @(posedge clk);
    model_edge(rst_s, raw_s);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_raw = 6'h3F;
    for (int k = 0; k < 3; k++) begin
      tick(); exp_v = exp_q.pop_front();
      checks++; if (obs !== '0) begin failures++; $display("FAIL reset_hold k=%0d got=%h exp=0", k, obs); end
      checks++; if (obs !== exp_v) begin failures++; $display("FAIL reset_model k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(); exp_v = exp_q.pop_front();
      checks++; if (btn_press !== ((k == 5) ? 6'h3F : 6'h00)) begin failures++; $display("FAIL reset_press k=%0d got=%h", k, btn_press); end
      checks++; if (btn_level !== ((k >= 5) ? 6'h3F : 6'h00)) begin failures++; $display("FAIL reset_level k=%0d got=%h", k, btn_level); end
      checks++; if (obs !== exp_v) begin failures++; $display("FAIL reset_model k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
    btn_raw = '0;
    for (int k = 0; k < 12; k++) begin
      tick(); exp_v = exp_q.pop_front();
      checks++; if (obs !== exp_v) begin failures++; $display("FAIL reset_settle k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
  endtask

  task automatic test_short_press();
    btn_raw = 6'h01;
    for (int k = 0; k < 10; k++) begin
      tick(); exp_v = exp_q.pop_front();
      checks++; if (btn_press[0] !== (k == 5)) begin failures++; $display("FAIL short_press k=%0d got=%b", k, btn_press[0]); end
      checks++; if (btn_level[0] !== (k >= 5)) begin failures++; $display("FAIL short_level_up k=%0d got=%b", k, btn_level[0]); end
      checks++; if (obs !== exp_v) begin failures++; $display("FAIL short_model k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
    btn_raw = '0;
    for (int k = 0; k < 12; k++) begin
      tick(); exp_v = exp_q.pop_front();
      checks++; if (btn_short[0] !== (k == 5)) begin failures++; $display("FAIL short_pulse k=%0d got=%b", k, btn_short[0]); end
      checks++; if (btn_level[0] !== (k < 5)) begin failures++; $display("FAIL short_level_dn k=%0d got=%b", k, btn_level[0]); end
      checks++; if (btn_long !== '0) begin failures++; $display("FAIL short_no_long k=%0d got=%h", k, btn_long); end
      checks++; if (obs !== exp_v) begin failures++; $display("FAIL short_model k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    pat = 6'b011011;  // 1,1,0,1,1,0 from bit 0
    for (int k = 0; k < 14; k++) begin
      btn_raw = (k < 6) ? {3'b000, pat[k], 2'b00} : 6'h00;
      tick(); exp_v = exp_q.pop_front();
      checks++; if (obs !== '0) begin failures++; $display("FAIL bounce_quiet k=%0d got=%h exp=0", k, obs); end
      checks++; if (obs !== exp_v) begin failures++; $display("FAIL bounce_model k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
    for (int k = 0; k < 32; k++) begin
      btn_raw = ((k < 8) || (k >= 10 && k < 20)) ? 6'h04 : 6'h00;
      tick(); exp_v = exp_q.pop_front();
      if (k >= 6 && k <= 24) begin
        checks++; if (btn_level[2] !== 1'b1 || btn_press[2] !== 1'b0 || btn_short[2] !== 1'b0) begin
          failures++; $display("FAIL glitch_held k=%0d got=%h", k, obs);
        end
      end
      checks++; if (btn_short[2] !== (k == 25)) begin failures++; $display("FAIL glitch_short k=%0d got=%b", k, btn_short[2]); end
      checks++; if (obs !== exp_v) begin failures++; $display("FAIL glitch_model k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
  endtask

  task automatic test_long_hold();
    for (int k = 0; k < 60; k++) begin
      btn_raw = ((k < 40) || (k >= 42 && k < 45)) ? 6'h10 : 6'h00;
      tick(); exp_v = exp_q.pop_front();
      checks++; if (btn_press[4] !== (k == 5)) begin failures++; $display("FAIL long_press k=%0d got=%b", k, btn_press[4]); end
      checks++; if (btn_long[4] !== (k == 25)) begin failures++; $display("FAIL long_pulse k=%0d got=%b", k, btn_long[4]); end
      checks++; if (btn_short[4] !== 1'b0) begin failures++; $display("FAIL long_no_short k=%0d got=%b", k, btn_short[4]); end
      checks++; if (btn_level[4] !== (k >= 5 && k < 50)) begin failures++; $display("FAIL long_level k=%0d got=%b", k, btn_level[4]); end
      checks++; if (obs !== exp_v) begin failures++; $display("FAIL long_model k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 45; k++) begin
      btn_raw = {2'b00, (k < 30), 1'b0, (k < 10), 1'b0};
      tick(); exp_v = exp_q.pop_front();
      checks++; if (btn_press !== ((k == 5) ? 6'h0A : 6'h00)) begin failures++; $display("FAIL simul_press k=%0d got=%h", k, btn_press); end
      checks++; if (btn_short !== ((k == 15) ? 6'h02 : 6'h00)) begin failures++; $display("FAIL simul_short k=%0d got=%h", k, btn_short); end
      checks++; if (btn_long !== ((k == 25) ? 6'h08 : 6'h00)) begin failures++; $display("FAIL simul_long k=%0d got=%h", k, btn_long); end
      checks++; if (obs !== exp_v) begin failures++; $display("FAIL simul_model k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
  endtask

  task automatic test_reset_mid_hold();
    btn_raw = 6'h20;
    for (int k = 0; k < 22; k++) begin
      reset = (k >= 20);
      tick(); exp_v = exp_q.pop_front();
      if (k >= 20) begin
        checks++; if (obs !== '0) begin failures++; $display("FAIL midrst_clear k=%0d got=%h exp=0", k, obs); end
      end else begin
        checks++; if (btn_press[5] !== (k == 5)) begin failures++; $display("FAIL midrst_press0 k=%0d got=%b", k, btn_press[5]); end
      end
      checks++; if (obs !== exp_v) begin failures++; $display("FAIL midrst_model k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick(); exp_v = exp_q.pop_front();
      checks++; if (btn_press[5] !== (k == 5)) begin failures++; $display("FAIL midrst_press k=%0d got=%b", k, btn_press[5]); end
      checks++; if (btn_long[5] !== (k == 25)) begin failures++; $display("FAIL midrst_long k=%0d got=%b", k, btn_long[5]); end
      checks++; if (obs !== exp_v) begin failures++; $display("FAIL midrst_model k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
    btn_raw = '0;
    for (int k = 0; k < 12; k++) begin
      tick(); exp_v = exp_q.pop_front();
      checks++; if (obs !== exp_v) begin failures++; $display("FAIL midrst_settle k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 99) < 6) btn_raw[i] = ~btn_raw[i];
      reset = ($urandom_range(0, 499) == 0);
      tick(); exp_v = exp_q.pop_front();
      checks++; if (obs !== exp_v) begin failures++; $display("FAIL random_model k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
    reset = 1'b0; btn_raw = '0;
    for (int k = 0; k < 12; k++) begin
      tick(); exp_v = exp_q.pop_front();
      checks++; if (obs !== exp_v) begin failures++; $display("FAIL random_settle k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = '0;
    test_reset();
    test_short_press();
    test_bounce();
    test_long_hold();
    test_simultaneous();
    test_reset_mid_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
